// File: rtl/conv_sequencer.sv
// Convolution sequencer: loads the 4x4 data and 3x3 filter from memory, runs
// one MAC per cycle over the four 2x2 output positions (conv + 3x3 max-pool),
// then offers the results back to memory. A watchdog aborts stalled waits.
module conv_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   ms,
  input  logic [127:0] data_bus,
  input  logic [71:0]  filter_bus,
  output logic [2:0]   mem_state,
  output logic [2:0]   cs,
  output logic [31:0]  ret22,
  output logic [31:0]  ret33,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StCompute, StWrite, StDone} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d, wait_inc;
  logic [1:0]         p_q, p_d, fr_q, fr_d, fc_q, fc_d;
  logic [19:0]        acc_q, acc_d, acc_sum;
  logic [7:0]         mx_q, mx_d, mx_new;
  logic [127:0]       data_q, data_d;
  logic [71:0]        filt_q, filt_d;
  logic [31:0]        ret22_q, ret22_d, ret33_q, ret33_d;
  logic               err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic [2:0]         mem_state_q, mem_state_d, cs_q, cs_d;

  logic [1:0]         row, col;
  logic [3:0]         fidx;
  logic [7:0]         d_byte, f_byte, sat;
  logic [15:0]        prod;

  // Datapath for the current tap: window element, product, running sum and max.
  always_comb begin
    row     = 2'(p_q[1]) + fr_q;
    col     = 2'(p_q[0]) + fc_q;
    fidx    = 4'(fr_q) * 4'd3 + 4'(fc_q);
    d_byte  = data_q[{row, col, 3'b000} +: 8];
    f_byte  = filt_q[{fidx, 3'b000} +: 8];
    prod    = 16'(d_byte) * 16'(f_byte);
    acc_sum = acc_q + 20'(prod);
    mx_new  = (d_byte > mx_q) ? d_byte : mx_q;
    // acc >> 8 exceeds a byte whenever any of bits 19:16 are set.
    sat     = (acc_sum[19:16] != 4'd0) ? 8'hFF : acc_sum[15:8];
    wait_inc = wait_q + WaitW'(1);
  end

  // Next-state logic; registered outputs are derived from the next state.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    p_d     = p_q;
    fr_d    = fr_q;
    fc_d    = fc_q;
    acc_d   = acc_q;
    mx_d    = mx_q;
    data_d  = data_q;
    filt_d  = filt_q;
    ret22_d = ret22_q;
    ret33_d = ret33_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          err_d   = 1'b0;
          wait_d  = '0;
        end
      end
      StLoad: begin
        if (ms == 3'b001) begin
          data_d  = data_bus;
          filt_d  = filter_bus;
          ret22_d = '0;
          ret33_d = '0;
          acc_d   = '0;
          mx_d    = '0;
          p_d     = '0;
          fr_d    = '0;
          fc_d    = '0;
          state_d = StCompute;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WaitW'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StCompute: begin
        if (fr_q == 2'd2 && fc_q == 2'd2) begin
          // Last tap of this position: commit results and reset for the next.
          ret22_d[{p_q, 3'b000} +: 8] = sat;
          ret33_d[{p_q, 3'b000} +: 8] = mx_new;
          acc_d = '0;
          mx_d  = '0;
          fr_d  = '0;
          fc_d  = '0;
          if (p_q == 2'd3) begin
            wait_d  = '0;
            state_d = StWrite;
          end else begin
            p_d = p_q + 2'd1;
          end
        end else begin
          acc_d = acc_sum;
          mx_d  = mx_new;
          if (fc_q == 2'd2) begin
            fc_d = '0;
            fr_d = fr_q + 2'd1;
          end else begin
            fc_d = fc_q + 2'd1;
          end
        end
      end
      StWrite: begin
        if (ms == 3'b010) begin
          state_d = StDone;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WaitW'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    unique case (state_d)
      StLoad:             mem_state_d = 3'b001;
      StCompute, StWrite: mem_state_d = 3'b010;
      default:            mem_state_d = 3'b000;
    endcase
    cs_d   = (state_d == StWrite) ? 3'b001 : 3'b000;
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      p_q         <= '0;
      fr_q        <= '0;
      fc_q        <= '0;
      acc_q       <= '0;
      mx_q        <= '0;
      data_q      <= '0;
      filt_q      <= '0;
      ret22_q     <= '0;
      ret33_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_state_q <= 3'b000;
      cs_q        <= 3'b000;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      p_q         <= p_d;
      fr_q        <= fr_d;
      fc_q        <= fc_d;
      acc_q       <= acc_d;
      mx_q        <= mx_d;
      data_q      <= data_d;
      filt_q      <= filt_d;
      ret22_q     <= ret22_d;
      ret33_q     <= ret33_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_state_q <= mem_state_d;
      cs_q        <= cs_d;
    end
  end

  assign mem_state = mem_state_q;
  assign cs        = cs_q;
  assign ret22     = ret22_q;
  assign ret33     = ret33_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: hand-computed results and cycle timing.
module tb_conv_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   ms;
  logic [127:0] data_bus;
  logic [71:0]  filter_bus;
  logic [2:0]   mem_state;
  logic [2:0]   cs;
  logic [31:0]  ret22;
  logic [31:0]  ret33;
  logic         busy;
  logic         done;
  logic         err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Results captured by do_run for the test tasks to compare.
  int          r_done_edge;
  logic        r_done, r_busy_start, r_busy_after, r_done_after, r_stable, r_timeout;
  logic [2:0]  r_ms_load, r_ms_comp, r_ms_done;

  logic [127:0] d_all16, d_ramp, d_all255;
  logic [71:0]  f_all16, f_centre, f_all255;

  conv_sequencer #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ms         (ms),
    .data_bus   (data_bus),
    .filter_bus (filter_bus),
    .mem_state  (mem_state),
    .cs         (cs),
    .ret22      (ret22),
    .ret33      (ret33),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full run. lw/ww: extra no-match cycles in LOAD/WRITE; spam: pulse start throughout.
  // Edge numbering: the edge that samples start is edge 0 (t0).
  task automatic do_run(input logic [127:0] d, input logic [71:0] f, input int lw,
                        input int ww, input bit spam);
    int t0;
    int n;
    logic [31:0] s22, s33;
    data_bus   = d;
    filter_bus = f;
    ms         = 3'b000;
    start      = 1'b1;
    step();
    start        = 1'b0;
    t0           = cyc;
    r_busy_start = busy;
    r_ms_load    = mem_state;
    repeat (lw) step();
    ms = 3'b001;
    step();
    ms        = 3'b000;
    r_ms_comp = mem_state;
    n = 0;
    while (cs !== 3'b001 && n < 80) begin
      start = spam & n[0];
      step();
      n++;
    end
    start     = 1'b0;
    r_timeout = (n >= 80);
    s22       = ret22;
    s33       = ret33;
    r_stable  = 1'b1;
    for (int i = 0; i < ww; i++) begin
      start = spam;
      step();
      if (cs !== 3'b001 || ret22 !== s22 || ret33 !== s33) r_stable = 1'b0;
    end
    ms    = 3'b010;
    start = spam;
    step();
    ms          = 3'b000;
    r_done      = done;
    r_done_edge = cyc - t0 + 1;
    r_ms_done   = mem_state;
    // A start coinciding with DONE -> IDLE must be ignored.
    start = spam;
    step();
    start        = 1'b0;
    r_busy_after = busy;
    r_done_after = done;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ms = 3'b000; data_bus = '0; filter_bus = '0;
    repeat (2) step();
    checks++; if (mem_state !== 3'b000) begin failures++; $display("FAIL reset_mem_state got=%h exp=0", mem_state); end
    checks++; if (cs !== 3'b000) begin failures++; $display("FAIL reset_cs got=%h exp=0", cs); end
    checks++; if ({ret22, ret33} !== 64'h0) begin failures++; $display("FAIL reset_ret got=%h exp=0", {ret22, ret33}); end
    checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, err}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_uniform();
    do_run(d_all16, f_all16, 0, 0, 1'b0);
    checks++; if (r_timeout !== 1'b0) begin failures++; $display("FAIL s1_reach_write got=timeout exp=write"); end
    checks++; if (r_busy_start !== 1'b1) begin failures++; $display("FAIL s1_busy_load got=%b exp=1", r_busy_start); end
    checks++; if (r_ms_load !== 3'b001) begin failures++; $display("FAIL s1_ms_load got=%h exp=1", r_ms_load); end
    checks++; if (r_ms_comp !== 3'b010) begin failures++; $display("FAIL s1_ms_comp got=%h exp=2", r_ms_comp); end
    checks++; if (r_done !== 1'b1 || r_done_edge != 39) begin failures++; $display("FAIL s1_done got=%b@%0d exp=1@39", r_done, r_done_edge); end
    checks++; if (r_ms_done !== 3'b000) begin failures++; $display("FAIL s1_ms_done got=%h exp=0", r_ms_done); end
    checks++; if (r_busy_after !== 1'b0 || r_done_after !== 1'b0) begin failures++; $display("FAIL s1_idle got=busy%b done%b exp=00", r_busy_after, r_done_after); end
    checks++; if (ret22 !== 32'h09090909) begin failures++; $display("FAIL s1_ret22 got=%h exp=09090909", ret22); end
    checks++; if (ret33 !== 32'h10101010) begin failures++; $display("FAIL s1_ret33 got=%h exp=10101010", ret33); end
  endtask

  task automatic test_ramp();
    do_run(d_ramp, f_centre, 0, 0, 1'b0);
    checks++; if (ret22 !== 32'h09080504) begin failures++; $display("FAIL ramp_ret22 got=%h exp=09080504", ret22); end
    checks++; if (ret33 !== 32'h0F0E0B0A) begin failures++; $display("FAIL ramp_ret33 got=%h exp=0F0E0B0A", ret33); end
  endtask

  task automatic test_saturate();
    do_run(d_all255, f_all255, 0, 0, 1'b0);
    checks++; if (ret22 !== 32'hFFFFFFFF) begin failures++; $display("FAIL sat_ret22 got=%h exp=FFFFFFFF", ret22); end
    checks++; if (ret33 !== 32'hFFFFFFFF) begin failures++; $display("FAIL sat_ret33 got=%h exp=FFFFFFFF", ret33); end
  endtask

  task automatic test_load_timeout();
    int t0;
    int n;
    logic seen_done;
    logic early_err;
    ms = 3'b000; start = 1'b1;
    step();
    start = 1'b0; t0 = cyc; n = 0; seen_done = 1'b0; early_err = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      step();
      n++;
      seen_done = seen_done | done;
      if (busy === 1'b1 && err !== 1'b0) early_err = 1'b1;
    end
    checks++; if (n != 16) begin failures++; $display("FAIL timeout_cycles got=%0d exp=16", n); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", err); end
    checks++; if (seen_done !== 1'b0 || early_err !== 1'b0) begin failures++; $display("FAIL timeout_flags got=done%b early_err%b exp=00", seen_done, early_err); end
    checks++; if (mem_state !== 3'b000) begin failures++; $display("FAIL timeout_mem_state got=%h exp=0", mem_state); end
    // Results from the previous run survive the abort.
    checks++; if (ret22 !== 32'hFFFFFFFF) begin failures++; $display("FAIL timeout_ret_hold got=%h exp=FFFFFFFF", ret22); end
    do_run(d_ramp, f_centre, 3, 0, 1'b0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL recover_err got=%b exp=0", err); end
    checks++; if (r_done !== 1'b1 || r_done_edge != 42) begin failures++; $display("FAIL recover_done got=%b@%0d exp=1@42", r_done, r_done_edge); end
    checks++; if (ret22 !== 32'h09080504) begin failures++; $display("FAIL recover_ret22 got=%h exp=09080504", ret22); end
  endtask

  task automatic test_write_wait();
    do_run(d_all16, f_all16, 0, 5, 1'b1);
    checks++; if (r_stable !== 1'b1) begin failures++; $display("FAIL wwait_stable got=%b exp=1", r_stable); end
    checks++; if (r_done !== 1'b1 || r_done_edge != 44) begin failures++; $display("FAIL wwait_done got=%b@%0d exp=1@44", r_done, r_done_edge); end
    checks++; if (r_busy_after !== 1'b0) begin failures++; $display("FAIL wwait_start_at_done got=busy%b exp=0", r_busy_after); end
    checks++; if (ret22 !== 32'h09090909 || ret33 !== 32'h10101010) begin failures++; $display("FAIL wwait_ret got=%h_%h exp=09090909_10101010", ret22, ret33); end
  endtask

  task automatic test_midrun_reset();
    data_bus = d_all255; filter_bus = f_all255; ms = 3'b000; start = 1'b1;
    step();
    start = 1'b0; ms = 3'b001;
    step();
    ms = 3'b000;
    repeat (20) step();
    rst = 1'b1;
    step();
    checks++; if ({ret22, ret33} !== 64'h0) begin failures++; $display("FAIL midrst_ret got=%h exp=0", {ret22, ret33}); end
    checks++; if ({mem_state, cs} !== 6'h0 || {busy, done, err} !== 3'b000) begin failures++; $display("FAIL midrst_ctrl got=%h_%b exp=0_000", {mem_state, cs}, {busy, done, err}); end
    rst = 1'b0;
    step();
    do_run(d_all16, f_all16, 0, 0, 1'b0);
    checks++; if (r_done !== 1'b1 || r_done_edge != 39) begin failures++; $display("FAIL midrst_done got=%b@%0d exp=1@39", r_done, r_done_edge); end
    checks++; if (ret22 !== 32'h09090909 || ret33 !== 32'h10101010) begin failures++; $display("FAIL midrst_ret_rerun got=%h_%h exp=09090909_10101010", ret22, ret33); end
  endtask

  initial begin
    d_all16  = {16{8'h10}};
    f_all16  = {9{8'h10}};
    d_all255 = {16{8'hFF}};
    f_all255 = {9{8'hFF}};
    for (int i = 0; i < 16; i++) d_ramp[8*i +: 8] = 8'(i);
    f_centre = '0;
    f_centre[8*4 +: 8] = 8'hFF;

    test_reset();
    test_uniform();
    test_ramp();
    test_saturate();
    test_load_timeout();
    test_write_wait();
    test_midrun_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
